// File: rtl/stage_memory_if.sv
// Single-beat bus between the memory stage (master) and the data memory (slave).
interface stage_memory_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/stage_memory.sv
// Memory stage: one bus transaction per load/store, ALU results pass through.
// Define MEMSTAGE_TIMEOUT_EN to abort a transaction after TIMEOUT_CYCLES without ack.
module stage_memory #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           stall_in,
  output logic           stall,
  input  logic [3:0]     in_addr,
  input  logic [31:0]    in_val,
  input  logic           is_mem,
  input  logic [31:0]    mem_addr,
  input  logic [31:0]    mem_val,
  input  logic           mem_write,
  output logic           fwd_valid,
  output logic [3:0]     fwd_addr,
  output logic [31:0]    fwd_val,
  output logic [3:0]     out_addr,
  output logic [31:0]    out_val,
  stage_memory_if.master bus,
  output logic           fault
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t      state, state_nxt;
  logic [3:0]  dest_p1;
  logic [31:0] rdata_p1;
  logic        issue, retire, fwd_load, timeout;
  logic [3:0]  out_addr_nxt;
  logic [31:0] out_val_nxt;

  if (TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("stage_memory: TIMEOUT_CYCLES must be >= 2");
  end

`ifdef MEMSTAGE_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt;

  // Abort only once writeback can take the bubble, so execute advances cleanly.
  assign timeout = (state == BUSY) && !bus.bus_ack && !stall_in && (tmo_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      fault   <= 1'b0;
    end else begin
      fault <= timeout;
      if (issue)
        tmo_cnt <= '0;
      else if (state == BUSY && !bus.bus_ack && tmo_cnt != CNT_LAST)
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign fault   = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    out_addr_nxt = out_addr;
    out_val_nxt  = out_val;
    issue        = 1'b0;
    retire       = 1'b0;
    fwd_load     = 1'b0;
    case (state)
      IDLE: begin
        if (!stall_in) begin
          if (is_mem) begin
            issue     = 1'b1;
            state_nxt = BUSY;
          end else begin
            out_addr_nxt = in_addr;
            out_val_nxt  = in_val;
          end
        end
      end
      BUSY: begin
        if (bus.bus_ack) begin
          if (stall_in) begin
            state_nxt = HOLD;
          end else begin
            retire       = 1'b1;
            fwd_load     = !bus.bus_we;
            state_nxt    = IDLE;
            out_addr_nxt = bus.bus_we ? 4'd0 : dest_p1;
            out_val_nxt  = bus.bus_we ? out_val : bus.bus_rdata;
          end
        end else begin
          out_addr_nxt = 4'd0;
          if (timeout) begin
            retire    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      HOLD: begin
        if (!stall_in) begin
          retire       = 1'b1;
          fwd_load     = !bus.bus_we;
          state_nxt    = IDLE;
          out_addr_nxt = bus.bus_we ? 4'd0 : dest_p1;
          out_val_nxt  = bus.bus_we ? out_val : rdata_p1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stall     = stall_in | (is_mem & ~retire);
  assign fwd_addr  = out_addr_nxt;
  assign fwd_val   = out_val_nxt;
  assign fwd_valid = (((state == IDLE) & ~is_mem & ~stall_in) | fwd_load) & (out_addr_nxt != 4'd0);

  // Control and writeback registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bus.bus_req <= 1'b0;
      bus.bus_we  <= 1'b0;
      out_addr    <= 4'd0;
      out_val     <= 32'd0;
    end else begin
      state       <= state_nxt;
      bus.bus_req <= (state_nxt == BUSY);
      out_addr    <= out_addr_nxt;
      out_val     <= out_val_nxt;
      if (issue)
        bus.bus_we <= mem_write;
    end
  end

  // Transaction payload, qualified by state
  always_ff @(posedge clk) begin
    if (issue) begin
      bus.bus_addr  <= mem_addr;
      bus.bus_wdata <= mem_val;
      dest_p1       <= in_addr;
    end
    if (state == BUSY && bus.bus_ack && stall_in)
      rdata_p1 <= bus.bus_rdata;
  end

endmodule

// File: tb/tb_stage_memory.sv
// Directed bench for stage_memory with a transaction-level reference model.
module tb_stage_memory;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_in = 1'b0;
  logic        stall;
  logic [3:0]  in_addr = '0;
  logic [31:0] in_val = '0;
  logic        is_mem = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_val = '0;
  logic        mem_write = 1'b0;
  logic        fwd_valid;
  logic [3:0]  fwd_addr;
  logic [31:0] fwd_val;
  logic [3:0]  out_addr;
  logic [31:0] out_val;
  logic        fault;

  int n_tests = 0;
  int n_fail  = 0;

  stage_memory_if bus_if ();

  stage_memory #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall_in  (stall_in),
    .stall     (stall),
    .in_addr   (in_addr),
    .in_val    (in_val),
    .is_mem    (is_mem),
    .mem_addr  (mem_addr),
    .mem_val   (mem_val),
    .mem_write (mem_write),
    .fwd_valid (fwd_valid),
    .fwd_addr  (fwd_addr),
    .fwd_val   (fwd_val),
    .out_addr  (out_addr),
    .out_val   (out_val),
    .bus       (bus_if),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  // Outstanding-transaction view of the stage
  typedef struct packed {
    logic        pend;
    logic        done;
    logic        load;
    logic        fault;
    logic        retire;
    logic        wrote;
    logic [3:0]  dest;
    logic [3:0]  oa;
    logic [31:0] ov;
    logic [31:0] data;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [15:0] waits;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t step(mdl_t s, logic si, logic im, logic [3:0] ia, logic [31:0] iv,
                                logic [31:0] ma, logic [31:0] mv, logic mw, logic ack,
                                logic [31:0] rd);
    mdl_t n = s;
    n.fault  = 1'b0;
    n.retire = 1'b0;
    n.wrote  = 1'b0;
    if (!s.pend) begin
      if (!si && im) begin
        n.pend = 1'b1; n.done = 1'b0; n.dest = ia; n.load = !mw;
        n.addr = ma; n.wdata = mv; n.waits = '0;
      end else if (!si) begin
        n.oa = ia; n.ov = iv; n.wrote = 1'b1;
      end
    end else if (s.done || ack) begin
      if (!si) begin
        n.pend = 1'b0; n.done = 1'b0; n.retire = 1'b1; n.wrote = s.load;
        n.oa = s.load ? s.dest : 4'd0;
        if (s.load) n.ov = s.done ? s.data : rd;
      end else if (!s.done) begin
        n.done = 1'b1; n.data = rd;
      end
    end else begin
      n.oa = 4'd0;
      n.waits = s.waits + 16'd1;
`ifdef MEMSTAGE_TIMEOUT_EN
      if (n.waits >= 16'(TMO) && !si) begin
        n.pend = 1'b0; n.retire = 1'b1; n.fault = 1'b1;
      end
`endif
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else m <= step(m, stall_in, is_mem, in_addr, in_val, mem_addr, mem_val, mem_write,
                   bus_if.bus_ack, bus_if.bus_rdata);
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    mdl_t nx;
    logic fv;
    logic breq;
    nx = step(m, stall_in, is_mem, in_addr, in_val, mem_addr, mem_val, mem_write,
              bus_if.bus_ack, bus_if.bus_rdata);
    fv   = nx.wrote && (nx.oa != 4'd0);
    breq = m.pend && !m.done;
    chk("stall", 32'(stall), 32'(stall_in | (is_mem & ~nx.retire)));
    chk("fwd_valid", 32'(fwd_valid), 32'(fv));
    if (fv) begin
      chk("fwd_addr", 32'(fwd_addr), 32'(nx.oa));
      chk("fwd_val", fwd_val, nx.ov);
    end
    chk("out_addr", 32'(out_addr), 32'(m.oa));
    chk("out_val", out_val, m.ov);
    chk("bus_req", 32'(bus_if.bus_req), 32'(breq));
    if (breq) begin
      chk("bus_we", 32'(bus_if.bus_we), 32'(!m.load));
      chk("bus_addr", bus_if.bus_addr, m.addr);
      chk("bus_wdata", bus_if.bus_wdata, m.wdata);
    end
    chk("fault", 32'(fault), 32'(m.fault));
  end

  task automatic cyc(logic si, logic im, logic [3:0] ia, logic [31:0] iv, logic [31:0] ma,
                     logic [31:0] mv, logic mw, logic ack, logic [31:0] rd);
    stall_in = si; is_mem = im; in_addr = ia; in_val = iv;
    mem_addr = ma; mem_val = mv; mem_write = mw;
    bus_if.bus_ack = ack; bus_if.bus_rdata = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_addr", 32'(out_addr), 32'd0);
    chk("rst bus_req", 32'(bus_if.bus_req), 32'd0);
    chk("rst fault", 32'(fault), 32'd0);
    rst_n = 1'b1;

    // ALU pass-through
    cyc(0, 0, 3, 32'h1234, 0, 0, 0, 0, 0);
    chk("alu addr", 32'(out_addr), 32'd3);
    chk("alu val", out_val, 32'h1234);

    // Load with ack on the second BUSY cycle
    cyc(0, 1, 5, 0, 32'h100, 0, 0, 0, 0);
    chk("ld req c1", 32'(bus_if.bus_req), 32'd1);
    cyc(0, 1, 5, 0, 32'h100, 0, 0, 0, 0);
    chk("ld req c2", 32'(bus_if.bus_req), 32'd1);
    chk("ld bubble", 32'(out_addr), 32'd0);
    cyc(0, 1, 5, 0, 32'h100, 0, 0, 1, 32'hDEADBEEF);
    chk("ld req drop", 32'(bus_if.bus_req), 32'd0);
    chk("ld addr", 32'(out_addr), 32'd5);
    chk("ld val", out_val, 32'hDEADBEEF);

    // Store
    cyc(0, 1, 7, 0, 32'h200, 32'hA5A5A5A5, 1, 0, 0);
    chk("st we", 32'(bus_if.bus_we), 32'd1);
    chk("st wdata", bus_if.bus_wdata, 32'hA5A5A5A5);
    cyc(0, 1, 7, 0, 32'h200, 32'hA5A5A5A5, 1, 1, 0);
    chk("st out_addr", 32'(out_addr), 32'd0);

    // Ack while writeback stalls for three cycles
    cyc(0, 0, 2, 32'h22, 0, 0, 0, 0, 0);
    cyc(0, 1, 9, 0, 32'h300, 0, 0, 0, 0);
    cyc(1, 1, 9, 0, 32'h300, 0, 0, 1, 32'hCAFEF00D);
    chk("hold req", 32'(bus_if.bus_req), 32'd0);
    cyc(1, 1, 9, 0, 32'h300, 0, 0, 0, 0);
    cyc(1, 1, 9, 0, 32'h300, 0, 0, 0, 0);
    chk("hold addr", 32'(out_addr), 32'd2);
    chk("hold val", out_val, 32'h22);
    cyc(0, 1, 9, 0, 32'h300, 0, 0, 0, 0);
    chk("release addr", 32'(out_addr), 32'd9);
    chk("release val", out_val, 32'hCAFEF00D);

    // Ack in IDLE ignored, then reset mid-transaction
    cyc(0, 0, 1, 32'h11, 0, 0, 0, 1, 32'hBAD);
    chk("idle ack", 32'(out_addr), 32'd1);
    cyc(0, 1, 4, 0, 32'h400, 0, 0, 0, 0);
    cyc(0, 1, 4, 0, 32'h400, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("async req", 32'(bus_if.bus_req), 32'd0);
    chk("async out", 32'(out_addr), 32'd0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 32'h77);
    chk("late req", 32'(bus_if.bus_req), 32'd0);
    chk("late val", out_val, 32'd0);

    // Load and store to dest 0, back to back, then ALU to dest 0
    cyc(0, 1, 0, 0, 32'h500, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 32'h500, 0, 0, 1, 32'h55);
    chk("ld0 val", out_val, 32'h55);
    cyc(0, 1, 0, 0, 32'h504, 32'h99, 1, 0, 0);
    chk("st0 req", 32'(bus_if.bus_req), 32'd1);
    cyc(0, 1, 0, 0, 32'h504, 32'h99, 1, 1, 0);
    cyc(0, 0, 0, 32'h44, 0, 0, 0, 0, 0);
    chk("alu0 val", out_val, 32'h44);

    // Writeback stall in IDLE holds outputs
    cyc(0, 0, 6, 32'h66, 0, 0, 0, 0, 0);
    cyc(1, 0, 7, 32'h77, 0, 0, 0, 0, 0);
    chk("stall hold", 32'(out_addr), 32'd6);

`ifdef MEMSTAGE_TIMEOUT_EN
    cyc(0, 1, 8, 0, 32'h600, 0, 0, 0, 0);
    repeat (TMO - 1) cyc(0, 1, 8, 0, 32'h600, 0, 0, 0, 0);
    chk("tmo pre fault", 32'(fault), 32'd0);
    cyc(0, 1, 8, 0, 32'h600, 0, 0, 0, 0);
    chk("tmo fault", 32'(fault), 32'd1);
    chk("tmo req", 32'(bus_if.bus_req), 32'd0);
    chk("tmo out", 32'(out_addr), 32'd0);
    cyc(0, 0, 3, 32'h33, 0, 0, 0, 0, 0);
    chk("tmo next", 32'(out_addr), 32'd3);
    chk("tmo pulse", 32'(fault), 32'd0);
`endif

    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
